// File: rtl/programmable_tick_counter_if.sv
// Signal bundle for programmable_tick_counter. The clk_out member exists only
// when TICK_COUNTER_CLKOUT_EN is defined.
interface programmable_tick_counter_if #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 30
);
   logic                 enable;
   logic [DIV_WIDTH-1:0] period;
   logic [WIDTH-1:0]     limit;
   logic                 up_down;
   logic                 load;
   logic [WIDTH-1:0]     load_value;
   logic [WIDTH-1:0]     out;
   logic                 tick;
   logic                 wrap;
`ifdef TICK_COUNTER_CLKOUT_EN
   logic                 clk_out;
`endif

   modport master (
      output enable, period, limit, up_down, load, load_value,
      input  out, tick, wrap
`ifdef TICK_COUNTER_CLKOUT_EN
      , input clk_out
`endif
   );

   modport slave (
      input  enable, period, limit, up_down, load, load_value,
      output out, tick, wrap
`ifdef TICK_COUNTER_CLKOUT_EN
      , output clk_out
`endif
   );
endinterface

// File: rtl/programmable_tick_counter.sv
// Prescaled up/down counter with programmable terminal count and load.
// Optional square-wave output clk_out is compiled in with TICK_COUNTER_CLKOUT_EN.
module programmable_tick_counter #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 30
) (
   input  logic                      clk_in,
   input  logic                      reset,
   programmable_tick_counter_if.slave bus
);
   logic [DIV_WIDTH-1:0] presc;
   logic [DIV_WIDTH-1:0] last;
   logic                 expire;
   logic [WIDTH-1:0]     count;
   logic [WIDTH-1:0]     term;
   logic [WIDTH-1:0]     stepped;
   logic                 step_wrap;
   logic                 tick_r;
   logic                 wrap_r;
`ifdef TICK_COUNTER_CLKOUT_EN
   logic                 clk_r;
`endif

   // ">=" rather than "==" so a period lowered mid-interval expires at once.
   always_comb begin
      last      = (bus.period == '0) ? '0 : bus.period - 1'b1;
      expire    = (presc >= last);
      term      = (bus.limit == '0) ? '1 : bus.limit;
      stepped   = count;
      step_wrap = 1'b0;
      if (bus.up_down) begin
         if (count >= term) begin
            stepped   = '0;
            step_wrap = 1'b1;
         end else begin
            stepped = count + 1'b1;
         end
      end else begin
         if ((count == '0) || (count > term)) begin
            stepped   = term;
            step_wrap = 1'b1;
         end else begin
            stepped = count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         presc  <= '0;
         count  <= '0;
         tick_r <= 1'b0;
         wrap_r <= 1'b0;
`ifdef TICK_COUNTER_CLKOUT_EN
         clk_r  <= 1'b0;
`endif
      end else begin
         tick_r <= 1'b0;
         wrap_r <= 1'b0;
         if (bus.enable) begin
            presc  <= expire ? '0 : presc + 1'b1;
            tick_r <= expire;
            if (expire && !bus.load) begin
               count  <= stepped;
               wrap_r <= step_wrap;
            end
`ifdef TICK_COUNTER_CLKOUT_EN
            if (expire) clk_r <= ~clk_r;
`endif
         end
         // Load wins over a coincident step but leaves the prescaler running.
         if (bus.load) count <= bus.load_value;
      end
   end

   assign bus.out  = count;
   assign bus.tick = tick_r;
   assign bus.wrap = wrap_r;
`ifdef TICK_COUNTER_CLKOUT_EN
   assign bus.clk_out = clk_r;
`endif
endmodule
